// File: rtl/axi_lite_pkg.sv
// Shared definitions for the command-driven AXI4-Lite master:
// FSM state encoding, AXI response codes, default bus widths and channel indices.
package axi_lite_pkg;

   // Default bus widths
   localparam int AXIL_ADDR_W = 32;
   localparam int AXIL_DATA_W = 32;

   // AXI4-Lite BRESP/RRESP encodings
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // State encodings kept as plain constants so older code can match on raw values
   localparam logic [2:0] ST_IDLE         = 3'd0;
   localparam logic [2:0] ST_WR_ADDR_DATA = 3'd1;
   localparam logic [2:0] ST_WR_RESP      = 3'd2;
   localparam logic [2:0] ST_RD_ADDR      = 3'd3;
   localparam logic [2:0] ST_RD_DATA      = 3'd4;
   localparam logic [2:0] ST_RSP          = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE         = ST_IDLE,
      S_WR_ADDR_DATA = ST_WR_ADDR_DATA,
      S_WR_RESP      = ST_WR_RESP,
      S_RD_ADDR      = ST_RD_ADDR,
      S_RD_DATA      = ST_RD_DATA,
      S_RSP          = ST_RSP
   } state_e;

   // Indices of the master-driven VALID channels
   localparam int CH_AW  = 0;
   localparam int CH_W   = 1;
   localparam int CH_AR  = 2;
   localparam int NUM_CH = 3;

   // Any response other than OKAY counts as an error
   function automatic logic resp_is_err(input logic [1:0] resp);
      return resp != RESP_OKAY;
   endfunction

endpackage

// File: rtl/axi_lite_chan_hs.sv
// Single AXI VALID holder. 'start' raises VALID, which stays up until the
// handshake; the handshake edge drops VALID and sets 'done'. 'done' is
// cleared by the next 'start'. 'fire' flags the handshake cycle itself.
module axi_lite_chan_hs (
   input  logic ACLK,
   input  logic ARESETn,
   input  logic start,
   input  logic ready,
   output logic valid,
   output logic done,
   output logic fire
);

   assign fire = valid & ready;

   // Hold VALID from start until handshake, then remember completion
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         valid <= 1'b0;
         done  <= 1'b0;
      end else if (start) begin
         valid <= 1'b1;
         done  <= 1'b0;
      end else if (fire) begin
         valid <= 1'b0;
         done  <= 1'b1;
      end
   end

endmodule

// File: rtl/axi_lite_master_cmd.sv
// Command-driven AXI4-Lite master: takes one read/write command at a time,
// runs the AXI4-Lite transaction and returns data/response on a valid/ready
// response port. Only one transaction is ever outstanding.
// Optional build macro AXIL_MASTER_ERRCNT_EN adds err_clr / err_count, a
// saturating count of non-OKAY B/R responses.
module axi_lite_master_cmd
   import axi_lite_pkg::*;
#(
   parameter int ADDR_W = AXIL_ADDR_W,
   parameter int DATA_W = AXIL_DATA_W
) (
   input  logic                  ACLK,
   input  logic                  ARESETn,
`ifdef AXIL_MASTER_ERRCNT_EN
   input  logic                  err_clr,
   output logic [15:0]           err_count,
`endif
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_W-1:0]     cmd_addr,
   input  logic [DATA_W-1:0]     cmd_wdata,
   input  logic [DATA_W/8-1:0]   cmd_wstrb,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_write,
   output logic [DATA_W-1:0]     rsp_data,
   output logic [1:0]            rsp_resp,
   output logic [ADDR_W-1:0]     M_AXI_AWADDR,
   output logic                  M_AXI_AWVALID,
   input  logic                  M_AXI_AWREADY,
   output logic [DATA_W-1:0]     M_AXI_WDATA,
   output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
   output logic                  M_AXI_WVALID,
   input  logic                  M_AXI_WREADY,
   input  logic [1:0]            M_AXI_BRESP,
   input  logic                  M_AXI_BVALID,
   output logic                  M_AXI_BREADY,
   output logic [ADDR_W-1:0]     M_AXI_ARADDR,
   output logic                  M_AXI_ARVALID,
   input  logic                  M_AXI_ARREADY,
   input  logic [DATA_W-1:0]     M_AXI_RDATA,
   input  logic [1:0]            M_AXI_RRESP,
   input  logic                  M_AXI_RVALID,
   output logic                  M_AXI_RREADY
);

   state_e              state_reg;
   logic                cmd_accept;
   logic [NUM_CH-1:0]   ch_start;
   logic [NUM_CH-1:0]   ch_ready;
   logic [NUM_CH-1:0]   ch_valid;
   logic [NUM_CH-1:0]   ch_done;
   logic [NUM_CH-1:0]   ch_fire;
   logic                aw_fin;
   logic                w_fin;
   logic                ar_fin;
   logic                b_fire;
   logic                r_fire;

   assign cmd_accept = (state_reg == S_IDLE) && cmd_ready && cmd_valid;
   assign b_fire     = M_AXI_BVALID & M_AXI_BREADY;
   assign r_fire     = M_AXI_RVALID & M_AXI_RREADY;

   // A channel is finished either from an earlier handshake or one happening now
   assign aw_fin = ch_done[CH_AW] | ch_fire[CH_AW];
   assign w_fin  = ch_done[CH_W]  | ch_fire[CH_W];
   assign ar_fin = ch_done[CH_AR] | ch_fire[CH_AR];

   assign ch_ready[CH_AW] = M_AXI_AWREADY;
   assign ch_ready[CH_W]  = M_AXI_WREADY;
   assign ch_ready[CH_AR] = M_AXI_ARREADY;

   assign M_AXI_AWVALID = ch_valid[CH_AW];
   assign M_AXI_WVALID  = ch_valid[CH_W];
   assign M_AXI_ARVALID = ch_valid[CH_AR];

   // Launch AW+W together for a write, AR alone for a read
   always_comb begin
      ch_start        = '0;
      ch_start[CH_AW] = cmd_accept & cmd_write;
      ch_start[CH_W]  = cmd_accept & cmd_write;
      ch_start[CH_AR] = cmd_accept & ~cmd_write;
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
         axi_lite_chan_hs u_hs (
            .ACLK    (ACLK),
            .ARESETn (ARESETn),
            .start   (ch_start[gi]),
            .ready   (ch_ready[gi]),
            .valid   (ch_valid[gi]),
            .done    (ch_done[gi]),
            .fire    (ch_fire[gi])
         );
      end
   endgenerate

   // Transaction sequencer: command accept, B/R ready control, response hold
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state_reg    <= S_IDLE;
         cmd_ready    <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_write    <= 1'b0;
         rsp_data     <= '0;
         rsp_resp     <= RESP_OKAY;
         M_AXI_AWADDR <= '0;
         M_AXI_WDATA  <= '0;
         M_AXI_WSTRB  <= '0;
         M_AXI_ARADDR <= '0;
         M_AXI_BREADY <= 1'b0;
         M_AXI_RREADY <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (cmd_accept) begin
                  cmd_ready <= 1'b0;
                  if (cmd_write) begin
                     M_AXI_AWADDR <= cmd_addr;
                     M_AXI_WDATA  <= cmd_wdata;
                     M_AXI_WSTRB  <= cmd_wstrb;
                     state_reg    <= S_WR_ADDR_DATA;
                  end else begin
                     M_AXI_ARADDR <= cmd_addr;
                     state_reg    <= S_RD_ADDR;
                  end
               end else begin
                  // Also raises cmd_ready on the first cycle out of reset
                  cmd_ready <= 1'b1;
               end
            end
            S_WR_ADDR_DATA: begin
               if (aw_fin && w_fin) begin
                  M_AXI_BREADY <= 1'b1;
                  state_reg    <= S_WR_RESP;
               end
            end
            S_WR_RESP: begin
               if (b_fire) begin
                  M_AXI_BREADY <= 1'b0;
                  rsp_valid    <= 1'b1;
                  rsp_write    <= 1'b1;
                  rsp_data     <= '0;
                  rsp_resp     <= M_AXI_BRESP;
                  state_reg    <= S_RSP;
               end
            end
            S_RD_ADDR: begin
               if (ar_fin) begin
                  M_AXI_RREADY <= 1'b1;
                  state_reg    <= S_RD_DATA;
               end
            end
            S_RD_DATA: begin
               if (r_fire) begin
                  M_AXI_RREADY <= 1'b0;
                  rsp_valid    <= 1'b1;
                  rsp_write    <= 1'b0;
                  rsp_data     <= M_AXI_RDATA;
                  rsp_resp     <= M_AXI_RRESP;
                  state_reg    <= S_RSP;
               end
            end
            S_RSP: begin
               if (rsp_valid && rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state_reg <= S_IDLE;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

`ifdef AXIL_MASTER_ERRCNT_EN
   logic err_evt;
   assign err_evt = (b_fire && resp_is_err(M_AXI_BRESP)) ||
                    (r_fire && resp_is_err(M_AXI_RRESP));

   // Saturating error counter; clear wins over a same-cycle increment
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         err_count <= '0;
      end else if (err_clr) begin
         err_count <= '0;
      end else if (err_evt && (err_count != 16'hFFFF)) begin
         err_count <= err_count + 16'd1;
      end
   end
`endif

endmodule
